// File: rtl/dcim_weight_feeder.sv
// Weight feeder for the 16x8 DCIM multiplier macro: buffers one weight load, resets the
// macro, replays the weights as a contiguous init burst, then forwards activations.
module dcim_weight_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_COUNT   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int MRST_CYCLES  = 2,
  parameter int DONE_TIMEOUT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_req,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  mac_rst_n,
  output logic                  pe_ce,
  output logic                  init_enable,
  output logic [DATA_WIDTH-1:0] mac_data,
  input  logic                  init_done,
  output logic [ADDR_WIDTH-1:0] act_idx,
  output logic                  busy,
  output logic                  weights_ok,
  output logic                  err
);

  // state       | meaning
  // S_IDLE      | no weights loaded, macro released from reset
  // S_FILL      | collecting ADDR_COUNT weight bytes
  // S_MRST      | mac_rst_n held low for MRST_CYCLES
  // S_BURST     | B0..B16 replay, pe_ce high every cycle
  // S_WAIT_DONE | waiting up to DONE_TIMEOUT cycles for init_done
  // S_STREAM    | forwarding activations
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_MRST, S_BURST, S_WAIT_DONE, S_STREAM
  } state_t;

  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = 8;
  localparam logic [CW-1:0] LAST_IDX   = CW'(ADDR_COUNT - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(ADDR_COUNT);
  localparam logic [TW-1:0] MRST_LOAD  = TW'(MRST_CYCLES - 1);
  localparam logic [TW-1:0] DONE_LOAD  = TW'(DONE_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [ADDR_WIDTH-1:0] act_cnt_q, act_cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [ADDR_COUNT];
  logic [DATA_WIDTH-1:0] buf_d [ADDR_COUNT];

  logic                  s_ready_q, s_ready_d;
  logic                  mac_rst_n_q, mac_rst_n_d;
  logic                  pe_ce_q, pe_ce_d;
  logic                  init_enable_q, init_enable_d;
  logic [DATA_WIDTH-1:0] mac_data_q, mac_data_d;
  logic [ADDR_WIDTH-1:0] act_idx_q, act_idx_d;
  logic                  busy_q, busy_d;
  logic                  weights_ok_q, weights_ok_d;
  logic                  err_q, err_d;

  logic                  hs;
  logic [CW-1:0]         cnt_inc;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    act_cnt_d     = act_cnt_q;
    buf_d         = buf_q;
    pe_ce_d       = 1'b0;
    init_enable_d = 1'b0;
    mac_data_d    = mac_data_q;
    act_idx_d     = act_idx_q;
    err_d         = err_q;
    hs            = s_valid && s_ready_q;
    cnt_inc       = cnt_q + CW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_FILL;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_FILL: begin
        if (hs) begin
          buf_d[cnt_q[ADDR_WIDTH-1:0]] = s_data;
          cnt_d = cnt_inc;
          if (cnt_q == LAST_IDX) begin
            state_d = S_MRST;
            tmr_d   = MRST_LOAD;
          end
        end
      end
      S_MRST: begin
        if (tmr_q == '0) begin
          state_d       = S_BURST;
          cnt_d         = '0;
          pe_ce_d       = 1'b1;
          init_enable_d = 1'b1;
          mac_data_d    = buf_q[0];
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_BURST: begin
        // cnt_q is the index of the burst cycle currently on the outputs
        if (cnt_q == BURST_LAST) begin
          state_d = S_WAIT_DONE;
          tmr_d   = DONE_LOAD;
        end else begin
          cnt_d      = cnt_inc;
          pe_ce_d    = 1'b1;
          mac_data_d = (cnt_inc == BURST_LAST) ? '0 : buf_q[cnt_inc[ADDR_WIDTH-1:0]];
        end
      end
      S_WAIT_DONE: begin
        if (init_done) begin
          state_d   = S_STREAM;
          act_cnt_d = '0;
          act_idx_d = '0;
        end else if (tmr_q == '0) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_STREAM: begin
        if (hs) begin
          pe_ce_d    = 1'b1;
          mac_data_d = s_data;
          act_idx_d  = act_cnt_q;
          act_cnt_d  = act_cnt_q + ADDR_WIDTH'(1);
        end
        if (!init_done) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (load_req) begin
          state_d = S_FILL;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d    = (state_d == S_FILL) || (state_d == S_STREAM);
    mac_rst_n_d  = (state_d != S_MRST);
    busy_d       = (state_d == S_FILL) || (state_d == S_MRST) ||
                   (state_d == S_BURST) || (state_d == S_WAIT_DONE);
    weights_ok_d = (state_d == S_STREAM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      act_cnt_q     <= '0;
      buf_q         <= '{default: '0};
      s_ready_q     <= 1'b0;
      mac_rst_n_q   <= 1'b0;
      pe_ce_q       <= 1'b0;
      init_enable_q <= 1'b0;
      mac_data_q    <= '0;
      act_idx_q     <= '0;
      busy_q        <= 1'b0;
      weights_ok_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      act_cnt_q     <= act_cnt_d;
      buf_q         <= buf_d;
      s_ready_q     <= s_ready_d;
      mac_rst_n_q   <= mac_rst_n_d;
      pe_ce_q       <= pe_ce_d;
      init_enable_q <= init_enable_d;
      mac_data_q    <= mac_data_d;
      act_idx_q     <= act_idx_d;
      busy_q        <= busy_d;
      weights_ok_q  <= weights_ok_d;
      err_q         <= err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign mac_rst_n   = mac_rst_n_q;
  assign pe_ce       = pe_ce_q;
  assign init_enable = init_enable_q;
  assign mac_data    = mac_data_q;
  assign act_idx     = act_idx_q;
  assign busy        = busy_q;
  assign weights_ok  = weights_ok_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dcim_weight_feeder.sv
// Scoreboard bench for dcim_weight_feeder: expected macro beats are queued as stimulus is
// issued; a negedge monitor with a small macro model pops and compares every pe_ce beat.
module tb_dcim_weight_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_req = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       mac_rst_n;
  logic       pe_ce;
  logic       init_enable;
  logic [7:0] mac_data;
  logic       init_done = 1'b0;
  logic [3:0] act_idx;
  logic       busy;
  logic       weights_ok;
  logic       err;

  dcim_weight_feeder dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .mac_rst_n(mac_rst_n), .pe_ce(pe_ce), .init_enable(init_enable),
    .mac_data(mac_data), .init_done(init_done), .act_idx(act_idx), .busy(busy),
    .weights_ok(weights_ok), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    bit          ie;
    bit          is_act;
    logic [3:0]  idx;
    logic [15:0] prod;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         pe_cnt = 0;
  logic [7:0] wts [16];
  logic [3:0] act_next = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // macro model: captures the init burst, then multiplies stored weight by each activation
  logic [7:0]  mem [16];
  int          mmode = 0;
  int          mptr = 0;
  logic [15:0] mprod;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n || mac_rst_n === 1'b0) mmode = 0;
    if (rst_n && pe_ce === 1'b1) begin
      pe_cnt++;
      mprod = '1;
      if (init_enable === 1'b1) begin
        mmode = 1;
        mptr  = 0;
      end
      if (mmode == 1) begin
        if (mptr < 16) mem[mptr] = mac_data;
        mptr++;
        if (mptr == 17) begin
          mmode = 2;
          mptr  = 0;
        end
      end else if (mmode == 2) begin
        mprod = 16'(mem[mptr]) * 16'(mac_data);
        mptr  = (mptr + 1) % 16;
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pe_ce beat data %0h, required no beat", mac_data);
      end else begin
        e = sb.pop_front();
        chk("mac_data", mac_data, e.data);
        chk("init_enable", init_enable, e.ie);
        if (e.is_act) begin
          chk("act_idx", act_idx, e.idx);
          chk("product", mprod, e.prod);
        end
      end
    end
  end

  task automatic push_burst();
    exp_t x;
    for (int k = 0; k < 17; k++) begin
      x.data   = (k < 16) ? wts[k] : 8'h00;
      x.ie     = (k == 0);
      x.is_act = 1'b0;
      x.idx    = '0;
      x.prod   = '0;
      sb.push_back(x);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // drives from a negedge; returns at the first MRST-cycle sample
  task automatic send_weights(input bit gaps);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 400) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = wts[i];
        if (s_ready) i++;
      end
      guard++;
      if (i < 16) @(negedge clk);
    end
    chk("fill_beats", i, 16);
    push_burst();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic run_burst(input bit give_done);
    int n, lowc, pec;
    n = 0;
    while (mac_rst_n !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    lowc = 0;
    while (mac_rst_n === 1'b0 && lowc < 40) begin @(negedge clk); lowc++; end
    chk("mrst_len", lowc, 2);
    pec = 0;
    while (pe_ce === 1'b1 && pec < 40) begin @(negedge clk); pec++; end
    chk("burst_len", pec, 17);
    if (give_done) begin
      init_done = 1'b1;
      act_next  = '0;
    end
  endtask

  task automatic send_acts(input int n);
    int sent, guard;
    exp_t x;
    sent = 0;
    guard = 0;
    while (sent < n && guard < 400) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = 8'hA0 ^ 8'(sent * 7);
        if (s_ready) begin
          x.data = s_data; x.ie = 1'b0; x.is_act = 1'b1; x.idx = act_next;
          x.prod = 16'(wts[act_next]) * 16'(s_data);
          sb.push_back(x);
          act_next = act_next + 4'd1;
          sent++;
        end
      end
      guard++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("act_beats", sent, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  start;
    int  n;
    exp_t x;

    // reset values
    repeat (2) @(negedge clk);
    chk("reset_outputs", {s_ready, mac_rst_n, pe_ce, init_enable, busy, weights_ok, err,
                          mac_data, act_idx}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_mac_rst_n", mac_rst_n, 1);
    chk("idle_s_ready", s_ready, 0);

    // load 0x01..0x10 with s_valid held high
    for (int i = 0; i < 16; i++) wts[i] = 8'(i + 1);
    pulse_load();
    chk("fill_busy", busy, 1);
    send_weights(1'b0);
    chk("s_ready_drop", s_ready, 0);
    run_burst(1'b1);
    @(negedge clk);
    chk("stream_weights_ok", weights_ok, 1);
    chk("stream_act_idx0", act_idx, 0);
    chk("stream_busy", busy, 0);

    // 20 activations with bubbles
    start = pe_cnt;
    send_acts(20);
    @(negedge clk);
    chk("act_pe_count", pe_cnt - start, 20);

    // load_req together with an accepted activation
    chk("stream_s_ready", s_ready, 1);
    load_req = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'h5A;
    x.data = 8'h5A; x.ie = 1'b0; x.is_act = 1'b1; x.idx = act_next;
    x.prod = 16'(wts[act_next]) * 16'h005A;
    sb.push_back(x);
    act_next = act_next + 4'd1;
    @(negedge clk);
    load_req = 1'b0;
    s_valid  = 1'b0;
    chk("lr_pe_ce", pe_ce, 1);
    chk("lr_weights_ok", weights_ok, 0);
    chk("lr_busy", busy, 1);
    chk("lr_fill_ready", s_ready, 1);
    init_done = 1'b0;

    // reload with gaps, init_done never arrives
    send_weights(1'b1);
    run_burst(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("err_early", err, 0);
      @(negedge clk);
    end
    chk("err_timeout", err, 1);
    chk("err_idle_busy", busy, 0);
    chk("err_idle_ok", weights_ok, 0);
    pulse_load();
    chk("err_cleared", err, 0);

    // reset pulsed at B8 of a burst
    for (int i = 0; i < 16; i++) wts[i] = 8'h80 + 8'(i);
    send_weights(1'b0);
    n = 0;
    while (pe_ce !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    chk("b8_pe_ce", pe_ce, 1);
    #2 rst_n = 1'b0;
    #1 chk("midburst_reset", {s_ready, mac_rst_n, pe_ce, init_enable, busy, weights_ok, err,
                              mac_data, act_idx}, '0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fresh load after reset
    for (int i = 0; i < 16; i++) wts[i] = 8'h40 + 8'(i * 3);
    pulse_load();
    send_weights(1'b1);
    run_burst(1'b1);
    @(negedge clk);
    chk("reload_weights_ok", weights_ok, 1);
    send_acts(5);
    @(negedge clk);

    // init_done falling in STREAM
    init_done = 1'b0;
    @(negedge clk);
    chk("drop_err", err, 1);
    chk("drop_weights_ok", weights_ok, 0);
    chk("drop_s_ready", s_ready, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
